// File: rtl/tm1638_responder_if.sv
// TM1638 serial link: clock, strobe and bidirectional data split into in/out/enable.
interface tm1638_responder_if;
    logic tm1638_clk;
    logic tm1638_stb;
    logic tm1638_dio_in;
    logic tm1638_dio_out;
    logic tm1638_dio_out_en;

    modport master (
        output tm1638_clk, tm1638_stb, tm1638_dio_in,
        input  tm1638_dio_out, tm1638_dio_out_en
    );

    modport slave (
        input  tm1638_clk, tm1638_stb, tm1638_dio_in,
        output tm1638_dio_out, tm1638_dio_out_en
    );
endinterface

// File: rtl/tm1638_responder.sv
// Device-side TM1638 responder: oversampled serial decode, 16-byte display RAM,
// display control and key-scan readback.
module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset,
    tm1638_responder_if.slave   bus,
    input  logic [31:0]         keys,
    input  logic [3:0]          disp_addr,
    output logic [7:0]          disp_data,
    output logic                display_on,
    output logic [2:0]          brightness,
    output logic                frame_done,
    output logic                protocol_error
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE_DATA,
        READ_KEYS,
        IGNORE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] clk_sync, stb_sync, dio_sync;
    logic clk_s, stb_s, dio_s, clk_q, stb_q;
    logic clk_rise, clk_fall, stb_rise, stb_fall;

    logic [6:0]  sreg;
    logic [7:0]  next_byte;
    logic [2:0]  bit_cnt;
    logic [1:0]  rd_bytes;
    logic        byte_done, any_byte;
    logic [3:0]  addr;
    logic        fixed_mode;
    logic [31:0] snap;
    logic [4:0]  key_idx;
    logic        dio_out, dio_oe;
    logic [7:0]  ram [16];

    logic ram_we, snap_we, fixed_we, addr_we, ctrl_we, err_set;

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign stb_s = stb_sync[SYNC_STAGES-1];
    assign dio_s = dio_sync[SYNC_STAGES-1];

    assign clk_rise  = clk_s & ~clk_q & ~stb_s;
    assign clk_fall  = ~clk_s & clk_q & ~stb_s;
    assign stb_rise  = stb_s & ~stb_q;
    assign stb_fall  = ~stb_s & stb_q;
    assign next_byte = {dio_s, sreg};
    assign byte_done = clk_rise && (state != IDLE) && (bit_cnt == 3'd7);

    assign bus.tm1638_dio_out    = dio_out;
    assign bus.tm1638_dio_out_en = dio_oe;

    // Reset loads the live line level so a frame in progress cannot fake an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync <= {SYNC_STAGES{bus.tm1638_clk}};
            stb_sync <= {SYNC_STAGES{bus.tm1638_stb}};
            dio_sync <= {SYNC_STAGES{bus.tm1638_dio_in}};
            clk_q    <= bus.tm1638_clk;
            stb_q    <= bus.tm1638_stb;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.tm1638_clk};
            stb_sync <= {stb_sync[SYNC_STAGES-2:0], bus.tm1638_stb};
            dio_sync <= {dio_sync[SYNC_STAGES-2:0], bus.tm1638_dio_in};
            clk_q    <= clk_s;
            stb_q    <= stb_s;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        snap_we    = 1'b0;
        fixed_we   = 1'b0;
        addr_we    = 1'b0;
        ctrl_we    = 1'b0;
        err_set    = 1'b0;
        if (stb_rise) begin
            state_next = IDLE;
            err_set    = (state != IDLE) && (bit_cnt != 3'd0);
        end else begin
            unique case (state)
                IDLE: if (stb_fall) state_next = CMD;
                CMD: if (byte_done) begin
                    unique case (next_byte[7:6])
                        2'b01: begin
                            fixed_we   = 1'b1;
                            snap_we    = next_byte[1];
                            state_next = next_byte[1] ? READ_KEYS : IGNORE;
                        end
                        2'b11: begin
                            addr_we    = 1'b1;
                            state_next = WRITE_DATA;
                        end
                        2'b10: begin
                            ctrl_we    = 1'b1;
                            state_next = IGNORE;
                        end
                        default: begin
                            err_set    = 1'b1;
                            state_next = IGNORE;
                        end
                    endcase
                end
                WRITE_DATA: ram_we = byte_done;
                READ_KEYS: begin
                    if (byte_done && rd_bytes == 2'd3) state_next = IGNORE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sreg           <= '0;
            bit_cnt        <= '0;
            rd_bytes       <= '0;
            any_byte       <= 1'b0;
            addr           <= '0;
            fixed_mode     <= 1'b0;
            snap           <= '0;
            key_idx        <= '0;
            dio_out        <= 1'b0;
            dio_oe         <= 1'b0;
            display_on     <= 1'b0;
            brightness     <= '0;
            frame_done     <= 1'b0;
            protocol_error <= 1'b0;
            disp_data      <= '0;
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else begin
            if (stb_fall || stb_rise)
                bit_cnt <= '0;
            else if (clk_rise && state != IDLE)
                bit_cnt <= bit_cnt + 3'd1;
            if (clk_rise && state != IDLE) sreg <= next_byte[7:1];

            if (stb_fall)       any_byte <= 1'b0;
            else if (byte_done) any_byte <= 1'b1;
            frame_done <= stb_rise && any_byte;

            if (snap_we) begin
                snap     <= keys;
                key_idx  <= '0;
                rd_bytes <= '0;
            end else if (state == READ_KEYS) begin
                if (clk_fall) begin
                    dio_out <= snap[key_idx];
                    key_idx <= key_idx + 5'd1;
                end
                if (byte_done) rd_bytes <= rd_bytes + 2'd1;
            end
            dio_oe <= (state_next == READ_KEYS);

            if (fixed_we) fixed_mode <= next_byte[2];
            if (addr_we)  addr <= next_byte[3:0];
            if (ctrl_we) begin
                display_on <= next_byte[3];
                brightness <= next_byte[2:0];
            end
            if (err_set) protocol_error <= 1'b1;

            if (ram_we) begin
                ram[addr] <= next_byte;
                if (!fixed_mode) addr <= addr + 4'd1;
            end
            disp_data <= ram[disp_addr];
        end
    end

endmodule
